// File: rtl/norm_round_pipe.sv
// Two-stage leading-one normaliser with optional round-to-nearest-even.
// S1 registers the raw product and its leading-zero count; S2 shifts, rounds and flags.
module norm_round_pipe #(
  parameter int unsigned IN_W  = 128,
  parameter int unsigned OUT_W = 52,
  parameter int unsigned CNT_W = $clog2(IN_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_rnd_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_mant,
  output logic [CNT_W-1:0]  out_lz,
  output logic              out_zero,
  output logic              out_inexact,
  output logic              out_carry
);

  localparam int unsigned LzLevels = $clog2(IN_W);
  localparam int unsigned LzPad    = 1 << LzLevels;

  // Pipeline state
  logic             s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]  s1_data_q, s1_data_d;
  logic             s1_rnd_q, s1_rnd_d;
  logic [CNT_W-1:0] s1_lz_q, s1_lz_d;
  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] mant_q, mant_d;
  logic [CNT_W-1:0] lz_q, lz_d;
  logic             zero_q, zero_d;
  logic             inexact_q, inexact_d;
  logic             carry_q, carry_d;

  logic s1_en, s2_en;

  // Leading-zero count: each level tests the top half of the remaining span and
  // shifts it away when empty, giving one count bit per level.
  logic [LzPad-1:0]    lzc_stage [LzLevels];
  logic [LzLevels-1:0] lzc_cnt;
  logic                in_is_zero;

  assign lzc_stage[0] = LzPad'(in_data) << (LzPad - IN_W);
  assign in_is_zero   = (in_data == '0);

  for (genvar k = 0; k < LzLevels; k++) begin : g_lzc
    localparam int unsigned Span = 1 << (LzLevels - 1 - k);
    assign lzc_cnt[LzLevels-1-k] = ~|lzc_stage[k][LzPad-1 -: Span];
    if (k < LzLevels - 1) begin : g_next
      assign lzc_stage[k+1] = lzc_cnt[LzLevels-1-k] ? (lzc_stage[k] << Span) : lzc_stage[k];
    end
  end

  // Handshake: a stage advances when its successor is empty or advancing.
  always_comb begin
    s2_en    = !s2_valid_q || out_ready;
    s1_en    = !s1_valid_q || s2_en;
    in_ready = s1_en;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_rnd_d   = s1_rnd_q;
    s1_lz_d    = s1_lz_q;
    if (s1_en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_rnd_d  = in_rnd_en;
        s1_lz_d   = in_is_zero ? CNT_W'(IN_W) : CNT_W'(lzc_cnt);
      end
    end
  end

  // S2 datapath: one extra zero LSB keeps the sticky range non-empty when OUT_W = IN_W-1.
  logic [IN_W:0]    shl;
  logic [OUT_W-1:0] window;
  logic             guard_bit, sticky_bit, round_up;
  logic [OUT_W:0]   sum;

  always_comb begin
    shl        = {s1_data_q, 1'b0} << s1_lz_q;
    window     = shl[IN_W -: OUT_W];
    guard_bit  = shl[IN_W-OUT_W];
    sticky_bit = |shl[IN_W-OUT_W-1:0];
    round_up   = s1_rnd_q && guard_bit && (sticky_bit || window[0]);
    sum        = {1'b0, window} + {{OUT_W{1'b0}}, round_up};
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    mant_d     = mant_q;
    lz_d       = lz_q;
    zero_d     = zero_q;
    inexact_d  = inexact_q;
    carry_d    = carry_q;
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        carry_d   = sum[OUT_W];
        mant_d    = sum[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : sum[OUT_W-1:0];
        lz_d      = s1_lz_q;
        zero_d    = (s1_lz_q == CNT_W'(IN_W));
        inexact_d = guard_bit || sticky_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_rnd_q   <= 1'b0;
      s1_lz_q    <= '0;
      s2_valid_q <= 1'b0;
      mant_q     <= '0;
      lz_q       <= '0;
      zero_q     <= 1'b0;
      inexact_q  <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_rnd_q   <= s1_rnd_d;
      s1_lz_q    <= s1_lz_d;
      s2_valid_q <= s2_valid_d;
      mant_q     <= mant_d;
      lz_q       <= lz_d;
      zero_q     <= zero_d;
      inexact_q  <= inexact_d;
      carry_q    <= carry_d;
    end
  end

  always_comb begin
    out_valid   = s2_valid_q;
    out_mant    = mant_q;
    out_lz      = lz_q;
    out_zero    = zero_q;
    out_inexact = inexact_q;
    out_carry   = carry_q;
  end

endmodule
